// File: rtl/gwas_pkg.sv
// rtl/gwas_pkg.sv - shared constants, state type and cell-index helper for the margin-table path
package gwas_pkg;

    localparam int NUM_CELLS = 6;
    localparam logic [1:0] GENO_MISSING = 2'd3;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Controls occupy cells 0..2 and cases 3..5, so cell[i] + cell[i+3] is the genotype margin.
    function automatic logic [2:0] cell_index(input logic [1:0] genotype, input logic phenotype);
        return 3'(genotype) + (phenotype ? 3'd3 : 3'd0);
    endfunction

endpackage

// File: rtl/margin_cell_counter.sv
// rtl/margin_cell_counter.sv - one contingency-table cell counter; saturation under MARGIN_SATURATE_EN
module margin_cell_counter
    import gwas_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_inc,
`ifdef MARGIN_SATURATE_EN
    output logic                  o_sat_next,
`endif
    output logic [DATA_WIDTH-1:0] o_next
);

    logic [DATA_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] w_next;

`ifdef MARGIN_SATURATE_EN
    logic r_sat;
    logic w_full;
    logic w_sat_next;

    assign w_full     = &r_count;
    assign w_next     = (i_inc && !w_full) ? r_count + DATA_WIDTH'(1) : r_count;
    // Flag records a dropped increment, not merely reaching the top value.
    assign w_sat_next = r_sat | (i_inc & w_full);
    assign o_sat_next = w_sat_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sat <= 1'b0;
        end else if (i_clr) begin
            r_sat <= 1'b0;
        end else begin
            r_sat <= w_sat_next;
        end
    end
`else
    assign w_next = i_inc ? r_count + DATA_WIDTH'(1) : r_count;
`endif

    // o_next includes this cycle's sample so the top can snapshot and clear in one edge.
    assign o_next = w_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

endmodule

// File: rtl/margin_table_builder.sv
// rtl/margin_table_builder.sv - double-buffered 2x3 genotype/phenotype table builder; option MARGIN_SATURATE_EN
module margin_table_builder
    import gwas_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sample_valid,
    output logic                            sample_ready,
    input  logic [1:0]                      genotype,
    input  logic                            phenotype,
    input  logic                            sample_last,
    output logic                            table_valid,
    input  logic                            table_ready,
`ifdef MARGIN_SATURATE_EN
    output logic                            sat_flag,
`endif
    output logic [NUM_CELLS*DATA_WIDTH-1:0] margin_table_out
);

    state_t                           r_state;
    logic                             r_sample_ready;
    logic                             r_table_valid;
    logic [NUM_CELLS*DATA_WIDTH-1:0]  r_table;

    logic                             w_accept;
    logic                             w_slot_free;
    logic                             w_clr;
    logic [2:0]                       w_idx;
    logic [NUM_CELLS-1:0]             w_inc;
    logic [NUM_CELLS*DATA_WIDTH-1:0]  w_next_table;

    assign w_accept    = sample_valid && r_sample_ready;
    assign w_slot_free = !r_table_valid || table_ready;
    assign w_idx       = cell_index(genotype, phenotype);

    // Counters clear on the same edge their contents move into the output register.
    assign w_clr = ((r_state == ACCUM) && w_accept && sample_last && w_slot_free) ||
                   ((r_state == HOLD) && table_ready);

`ifdef MARGIN_SATURATE_EN
    logic                 r_sat_flag;
    logic [NUM_CELLS-1:0] w_sat_next;
    assign sat_flag = r_sat_flag;
`endif

    genvar k;
    generate
        for (k = 0; k < NUM_CELLS; k++) begin : g_cell
            assign w_inc[k] = w_accept && (genotype != GENO_MISSING) && (w_idx == 3'(k));

            margin_cell_counter #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_cell (
                .clk        (clk),
                .rst        (rst),
                .i_clr      (w_clr),
                .i_inc      (w_inc[k]),
`ifdef MARGIN_SATURATE_EN
                .o_sat_next (w_sat_next[k]),
`endif
                .o_next     (w_next_table[k*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ACCUM;
            r_sample_ready <= 1'b1;
            r_table_valid  <= 1'b0;
            r_table        <= '0;
`ifdef MARGIN_SATURATE_EN
            r_sat_flag     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept && sample_last) begin
                        if (w_slot_free) begin
                            r_table       <= w_next_table;
                            r_table_valid <= 1'b1;
`ifdef MARGIN_SATURATE_EN
                            r_sat_flag    <= |w_sat_next;
`endif
                        end else begin
                            r_state        <= HOLD;
                            r_sample_ready <= 1'b0;
                        end
                    end else if (r_table_valid && table_ready) begin
                        r_table_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    // table_valid is necessarily high here; a drain immediately refills the slot.
                    if (table_ready) begin
                        r_table        <= w_next_table;
                        r_state        <= ACCUM;
                        r_sample_ready <= 1'b1;
`ifdef MARGIN_SATURATE_EN
                        r_sat_flag     <= |w_sat_next;
`endif
                    end
                end
                default: begin
                    r_state        <= ACCUM;
                    r_sample_ready <= 1'b1;
                end
            endcase
        end
    end

    assign sample_ready     = r_sample_ready;
    assign table_valid      = r_table_valid;
    assign margin_table_out = r_table;

endmodule

// File: tb/tb_margin_table_builder.sv
// tb/tb_margin_table_builder.sv - scoreboard bench for margin_table_builder; honours MARGIN_SATURATE_EN
module tb_margin_table_builder;

    localparam int DW   = 4;
    localparam int NC   = 6;
    localparam int MAXV = (1 << DW) - 1;

    typedef struct {
        logic [NC*DW-1:0] cells;
        bit               sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sample_valid = 1'b0;
    logic             sample_ready;
    logic [1:0]       genotype = 2'd0;
    logic             phenotype = 1'b0;
    logic             sample_last = 1'b0;
    logic             table_valid;
    logic             table_ready = 1'b0;
    logic [NC*DW-1:0] margin_table_out;
`ifdef MARGIN_SATURATE_EN
    logic             sat_flag;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];
    int   m_cnt[NC];
    bit   m_sat = 1'b0;
    bit   rand_mode = 1'b0;

    margin_table_builder #(.DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_valid     (sample_valid),
        .sample_ready     (sample_ready),
        .genotype         (genotype),
        .phenotype        (phenotype),
        .sample_last      (sample_last),
        .table_valid      (table_valid),
        .table_ready      (table_ready),
`ifdef MARGIN_SATURATE_EN
        .sat_flag         (sat_flag),
`endif
        .margin_table_out (margin_table_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NC*DW-1:0] pack_cells();
        logic [NC*DW-1:0] e;
        int v;
        e = '0;
        for (int c = 0; c < NC; c++) begin
            v = m_cnt[c];
            e[c*DW +: DW] = v[DW-1:0];
        end
        return e;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NC; c++) m_cnt[c] = 0;
        m_sat = 1'b0;
    endtask

    // Reference: count each non-missing sample into cell g+3p; publish the table on the last sample.
    task automatic model_accept(input int g, input int p, input bit last);
        exp_t e;
        int c;
        if (g != 3) begin
            c = g + 3 * p;
`ifdef MARGIN_SATURATE_EN
            if (m_cnt[c] == MAXV) m_sat = 1'b1;
            else m_cnt[c] = m_cnt[c] + 1;
`else
            m_cnt[c] = (m_cnt[c] + 1) % (MAXV + 1);
`endif
        end
        if (last) begin
            e.cells = pack_cells();
            e.sat   = m_sat;
            q.push_back(e);
            model_clear();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_sample(input int g, input int p, input bit last);
        int  waited;
        bit  ok;
        genotype     = 2'(g);
        phenotype    = p[0];
        sample_last  = last;
        sample_valid = 1'b1;
        waited = 0;
        ok = 1'b0;
        while (!ok && waited < 300) begin
            @(negedge clk);
            if (sample_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
                waited++;
            end
        end
        if (!ok) begin
            check("sample_accept_timeout", 64'd0, 64'd1);
            sample_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(g, p, last);
            #1;
            sample_valid = 1'b0;
            sample_last  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_table_valid", 64'(table_valid), 64'd0);
        check("rst_table_out", 64'(margin_table_out), 64'd0);
        check("rst_sample_ready", 64'(sample_ready), 64'd1);
        model_clear();
        q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: consumed tables are scored; held tables must not move.
    logic [NC*DW-1:0] held_data;
    bit               held = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", 64'(table_valid), 64'd1);
                    check("hold_stable", 64'(margin_table_out), 64'(held_data));
                end
                if (table_valid && table_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_table", 64'(margin_table_out), 64'hDEAD);
                    end else begin
                        e = q.pop_front();
                        check("table_cells", 64'(margin_table_out), 64'(e.cells));
`ifdef MARGIN_SATURATE_EN
                        check("sat_flag", 64'(sat_flag), 64'(e.sat));
`endif
                    end
                end
                held      = table_valid && !table_ready;
                held_data = margin_table_out;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) table_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int w;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("por_table_valid", 64'(table_valid), 64'd0);
        check("por_table_out", 64'(margin_table_out), 64'd0);
        check("por_sample_ready", 64'(sample_ready), 64'd1);
        rst = 1'b1;
        idle(1);

        // Basic table, one-cycle latency.
        table_ready = 1'b1;
        send_sample(0, 0, 0);
        send_sample(1, 0, 0);
        send_sample(2, 1, 0);
        send_sample(1, 1, 0);
        send_sample(2, 1, 1);
        check("latency_valid", 64'(table_valid), 64'd1);
        check("latency_cells", 64'(margin_table_out), {40'd0, 4'd2, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1});
        idle(2);

        // Slot busy: second table waits in HOLD.
        table_ready = 1'b0;
        send_sample(0, 0, 0);
        send_sample(1, 0, 0);
        send_sample(2, 1, 0);
        send_sample(1, 1, 0);
        send_sample(2, 1, 1);
        send_sample(0, 1, 0);
        send_sample(0, 1, 0);
        send_sample(0, 1, 1);
        check("hold_sample_ready", 64'(sample_ready), 64'd0);
        idle(3);
        table_ready = 1'b1;
        idle(1);
        table_ready = 1'b0;
        check("refill_valid", 64'(table_valid), 64'd1);
        check("refill_ready", 64'(sample_ready), 64'd1);
        check("refill_cells", 64'(margin_table_out), {40'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0});
        idle(2);
        table_ready = 1'b1;
        idle(2);

        // All-missing SNP still emits a zero table.
        send_sample(3, 0, 0);
        send_sample(3, 1, 1);
        check("zero_valid", 64'(table_valid), 64'd1);
        idle(1);

        // Back-to-back single-sample SNPs with no stall.
        send_sample(0, 0, 1);
        check("b2b_ready1", 64'(sample_ready), 64'd1);
        send_sample(2, 1, 1);
        check("b2b_ready2", 64'(sample_ready), 64'd1);
        check("b2b_valid", 64'(table_valid), 64'd1);
        idle(2);

        // 17 hits on one cell: wrap or saturate.
        for (int i = 0; i < 17; i++) send_sample(1, 0, (i == 16));
        idle(2);

        // Reset mid-SNP, then counts restart from 0.
        send_sample(0, 0, 0);
        send_sample(2, 1, 0);
        do_reset();
        table_ready = 1'b1;
        send_sample(1, 1, 1);
        idle(2);

        // Reset while a table is held.
        table_ready = 1'b0;
        send_sample(0, 0, 1);
        send_sample(1, 0, 1);
        check("hold2_sample_ready", 64'(sample_ready), 64'd0);
        do_reset();
        table_ready = 1'b1;
        send_sample(0, 1, 0);
        send_sample(0, 1, 1);
        idle(2);

        // Randomized SNPs with random backpressure.
        rand_mode = 1'b1;
        for (int s = 0; s < 60; s++) begin
            len = $urandom_range(1, 22);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send_sample($urandom_range(0, 3), $urandom_range(0, 1), (i == len - 1));
            end
        end
        rand_mode = 1'b0;
        table_ready = 1'b1;
        w = 0;
        while ((q.size() != 0 || table_valid) && w < 100) begin
            idle(1);
            w++;
        end
        check("drain_queue_empty", 64'(q.size()), 64'd0);
        check("drain_valid_low", 64'(table_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/margin_table_builder.md
Name: margin_table_builder

Overview:
- Producer side of the margin-table interface: streams per-sample (genotype, phenotype) pairs for one SNP and accumulates the 2x3 contingency table.
- Emits the table on the packed 6-cell bus consumed by the Pca calculation stage.
- Double-buffered: output register plus live counters, so accumulation of SNP n+1 overlaps the hold of SNP n's table.

Parameters:
- DATA_WIDTH, 16, width of each cell counter and of each cell on the output bus.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sample_valid  in  1  sample present
- sample_ready  out  1  builder accepts sample this cycle
- genotype  in  2  0/1/2 = minor-allele count; 3 = missing
- phenotype  in  1  0 = control, 1 = case
- sample_last  in  1  final sample of current SNP
- table_valid  out  1  margin_table_out holds a complete table
- table_ready  in  1  downstream consumes table this cycle
- margin_table_out  out  6*DATA_WIDTH  packed cells; cell k at bits [k*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Cell index k = genotype + 3*phenotype (k 0..2 controls, 3..5 cases); matches downstream divisor = cell[i] + cell[i+3].
- Sample accepted when sample_valid && sample_ready. Genotype 3 accepted but counts nothing.
- Accepted sample with genotype < 3: counter[k] += 1 next edge.
- Reset (rst low, async): all counters 0, margin_table_out 0, table_valid 0, state ACCUM. sample_ready therefore reads 1 out of reset.
- States:
  - ACCUM: sample_ready = 1.
  - HOLD: sample_ready = 0; counters frozen with the complete table.
- Output slot is free in a cycle iff !table_valid || table_ready.
- ACCUM, last sample accepted, slot free:
  - next edge margin_table_out <= counters including this sample; table_valid <= 1.
  - counters cleared to 0; remain in ACCUM.
  - Latency: last sample to table_valid is 1 cycle.
- ACCUM, last sample accepted, slot busy:
  - counters take final increment; go to HOLD.
- HOLD, table_ready high:
  - next edge copy counters to margin_table_out; table_valid stays 1.
  - clear counters; return to ACCUM.
- table_valid, table_ready high, no new transfer: table_valid <= 0; margin_table_out retains its value.
- table_valid held and margin_table_out stable while table_valid && !table_ready.
- Same-cycle drain and new last: new table replaces old with table_valid continuous; no bubble, no loss.
- Single-sample SNP and all-missing SNP are legal; an all-zero table is still emitted (zero-divisor handling is downstream's job).
- Counter overflow without the optional feature: wraps modulo 2^DATA_WIDTH.
- Reset mid-SNP: partial counts and any held table discarded.

Optional Feature:
- Macro: MARGIN_SATURATE_EN.
- Defined: each counter saturates at 2^DATA_WIDTH-1, and a sticky per-table flag sets.
  - Extra port sat_flag out 1, registered alongside margin_table_out.
  - Flag cleared with the counters.
- Undefined: wrap-around; no sat_flag port.

Decomposition:
- Shared package gwas_pkg holds:
  - NUM_CELLS = 6
  - GENO_MISSING = 2'd3
  - cell-index function (genotype + 3*phenotype)
  - state enum {ACCUM, HOLD}
- One natural sub-module, margin_cell_counter: per-cell counter with clear, inc and optional saturation. Instantiated 6x by generate.

Test Plan:
- Reset then samples (g,p) = (0,0),(1,0),(2,1),(1,1),(2,1) last, table_ready = 1 -> one cycle later table_valid = 1, cells [0..5] = 1,1,0,0,1,2.
- Same SNP with table_ready held 0, then second SNP of 3 samples all (0,1) last -> sample_ready drops after second last. On table_ready pulse: first table consumed, then cells = 0,0,0,3,0,0, sample_ready returns to 1.
- SNP of samples (3,0),(3,1) last -> all-zero table emitted with table_valid.
- Back-to-back single-sample SNPs (0,0) last, (2,1) last with table_ready = 1 -> consecutive tables {1,0,0,0,0,0} then {0,0,0,0,0,1}, no stall.
- DATA_WIDTH = 4, 17 samples (1,0):
  - without MARGIN_SATURATE_EN -> cell[1] = 1 (wrapped).
  - with MARGIN_SATURATE_EN -> cell[1] = 15 and sat_flag = 1.
- Assert rst low mid-SNP and during HOLD -> table_valid = 0, outputs 0 immediately; next SNP counts start from 0.
